serial_compare_fsm: RTL
=======================

Name: serial_compare_fsm

Overview:
- Sequential, MSB-first, bit-serial magnitude comparator for two unsigned WIDTH-bit operands.
- Examines one 2-bit digit per clock, from most significant to least significant.
- Stops at the first digit that differs and reports greater/less; reports equal when all digits match.
- Time-multiplexed counterpart of the combinational compare chain: one digit comparator is reused over several cycles instead of a WIDTH/2-deep LSB-first cascade.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2
DIGITS, WIDTH/2, derived (localparam): number of 2-bit digits per operand
CW, $clog2(DIGITS+1), derived (localparam): width of the digit counter and of the digits output

Ports:
clk  input  1  rising-edge clock, the only clock in the block
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only while ready=1
ready  output  1  high in IDLE; a start in this cycle is accepted
a  input  WIDTH  operand A; sampled on the accepting edge only
b  input  WIDTH  operand B; sampled on the accepting edge only
done  output  1  one-cycle pulse: result valid
greater  output  1  A > B
less  output  1  A < B
digits  output  CW  number of digits examined for the last result (1..DIGITS)

Interface (already decided):
- One clock; reset is asynchronous and active-low (rst_n).

Behaviour:
Reset:
- state=IDLE, ready=1, done=0, greater=0, less=0, digits=0.
- Shift registers and counter are cleared to 0.
- Asserting rst_n low at any point, including mid-RUN, aborts the operation immediately.
- No result is reported for an aborted operation.

States:
- IDLE:
  - ready=1.
  - When start=1: load sa<=a, sb<=b, cnt<=0, clear greater/less/digits, go to RUN.
  - When start=0: stay in IDLE.
- RUN:
  - ready=0.
  - Digit comparator evaluates sa[WIDTH-1:WIDTH-2] against sb[WIDTH-1:WIDTH-2].
  - If the digits differ: latch greater/less, set digits<=cnt+1, go to DONE.
  - Else, if cnt==DIGITS-1: equal; greater=less=0, digits<=DIGITS, go to DONE.
  - Else: shift sa and sb left by 2 (zero fill), cnt<=cnt+1, stay in RUN.
- DONE:
  - done=1 for exactly one cycle, ready=0.
  - Unconditionally go to IDLE on the next edge.

Timing:
- If start is accepted at edge k and the first differing digit has index i (0 = MSB), done is high in the cycle after edge k+i+1.
- That is a latency of i+2 cycles counted from the start cycle.
- Equal operands give a latency of DIGITS+1 cycles.

Output holding and start rules:
- greater, less and digits hold their value from DONE until the next accepted start.
- They are cleared on the accepting edge of that start.
- greater and less are never both 1.
- start while ready=0 is ignored; it does not queue.
- a and b may change freely after acceptance.
- The earliest next accept is the IDLE cycle immediately after DONE.

Arithmetic:
- Unsigned compare only.
- cnt is never allowed to wrap past DIGITS-1.

Decomposition:
- Package cmp_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
  - typedef struct packed {logic gt; logic lt;} cmp_res_t;
- Sub-module digit_cmp2 (combinational):
  - Inputs: 2-bit x, 2-bit y.
  - Outputs: gt, lt.
  - Instantiated once, on the top digit of the shift registers.
- The top level holds the FSM, the shift registers, the counter and the output registers.

Test Plan (WIDTH=8):
- Reset then idle: rst_n low, then high → ready=1, done=0, greater=less=0, digits=0; everything stays stable with start=0.
- Early decision: a=0xA5, b=0x25, start pulsed → done 2 cycles after start, greater=1, less=0, digits=1.
- Late decision: a=0x3C, b=0x3D → done 5 cycles after start, less=1, greater=0, digits=4.
- Equal operands: a=b=0x7E → done 5 cycles after start, greater=less=0, digits=4.
- Busy rejection: start a=0x01/b=0x00, then hold start=1 with a=0x00/b=0xFF during RUN → single result greater=1, digits=4, no second done pulse until IDLE has been seen again.
- Reset mid-RUN: a=0x03/b=0x02 started, rst_n low in the 2nd RUN cycle → outputs return to reset values asynchronously and no done pulse occurs. After release, a new start with 0x10/0x20 gives less=1, digits=2.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// FSM state encoding and the per-digit compare result.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
  } cmp_res_t;

endpackage

// File: rtl/digit_cmp2.sv
// Combinational unsigned compare of one 2-bit digit pair.
// Reused every cycle on the top digit of the operand shifters.
module digit_cmp2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_compare_fsm.sv
// MSB-first bit-serial magnitude comparator, one 2-bit digit per clock.
// Stops at the first differing digit; holds the result until the next start.
module serial_compare_fsm
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int DIGITS = WIDTH / 2,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             greater,
  output logic             less,
  output logic [CW-1:0]    digits
);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    digits_q, digits_d;
  cmp_res_t         res_q, res_d;
  cmp_res_t         dres;

  digit_cmp2 u_dcmp (
    .x  (sa_q[WIDTH-1 -: 2]),
    .y  (sb_q[WIDTH-1 -: 2]),
    .gt (dres.gt),
    .lt (dres.lt)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    digits_d = digits_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          cnt_d    = '0;
          res_d    = '0;
          digits_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (dres.gt || dres.lt) begin
          res_d    = dres;
          digits_d = cnt_q + CW'(1);
          state_d  = DONE;
        end else if (cnt_q == CW'(DIGITS - 1)) begin
          res_d    = '0;
          digits_d = CW'(DIGITS);
          state_d  = DONE;
        end else begin
          sa_d  = sa_q << 2;
          sb_d  = sb_q << 2;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      digits_q <= digits_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign greater = res_q.gt;
  assign less    = res_q.lt;
  assign digits  = digits_q;

endmodule
